// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus receive endpoint and its checker.
// get_dest extracts the destination-ID field that sits in the packet MSBs.
package bus_pkg;

  localparam int unsigned PKT_W = 16;
  localparam int unsigned ID_W  = 8;
  localparam logic [ID_W-1:0] BCAST_ID_DEFAULT = 8'hFF;

  typedef logic [PKT_W-1:0] pkt_t;

  function automatic logic [ID_W-1:0] get_dest(input logic [63:0] pkt, input int unsigned w);
    return ID_W'(pkt >> (w - ID_W));
  endfunction

endpackage

// File: rtl/rx_fifo_core.sv
// Circular-buffer FIFO with registered first-word-fall-through head.
// The top guarantees wr_en is only asserted when there is room or a pop is in flight.
module rx_fifo_core #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      count_q, count_d;
  logic [width-1:0] dout_q, dout_d;
  logic             rd_ok;

  always_comb begin
    rd_ok    = rd_en && (count_q != '0);
    rd_nxt   = rd_ptr_q + 1'b1;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_nxt : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The head register tracks what mem[rd_ptr] will hold after this edge,
    // so it must take din directly whenever the new head is being written now.
    dout_d = dout_q;
    if (count_q == '0) begin
      if (wr_en) dout_d = din;
    end else if (rd_ok) begin
      if (count_q == 1) begin
        if (wr_en) dout_d = din;
      end else begin
        dout_d = mem_q[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/bus_rx_endpoint.sv
// Bus receive endpoint: filters packets on destination ID, buffers matches in a FIFO,
// and counts drops due to ID mismatch or overflow (both saturating at 255).
module bus_rx_endpoint
  import bus_pkg::*;
#(
  parameter int unsigned     width    = 16,
  parameter int unsigned     depth    = 8,
  parameter int unsigned     id_w     = ID_W,
  parameter logic [id_w-1:0] my_id    = '0,
  parameter logic [id_w-1:0] bcast_id = BCAST_ID_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] D_push,
  input  logic             pop,
  output logic [width-1:0] D_pop,
  output logic             pndng,
  output logic             full,
  output logic [7:0]       ovf_cnt,
  output logic [7:0]       misrt_cnt
);

  localparam int unsigned CW = $clog2(depth) + 1;

  logic [CW-1:0]   count;
  logic [id_w-1:0] dest;
  logic            match, accept;
  logic [7:0]      ovf_q, ovf_d, misrt_q, misrt_d;

  assign full  = (count == CW'(depth));
  assign pndng = (count != '0);

  always_comb begin
    dest    = D_push[width-1 -: id_w];
    match   = (dest == my_id) || (dest == bcast_id);
    accept  = push && match && (!full || pop);
    ovf_d   = ovf_q;
    misrt_d = misrt_q;
    if (push && !match && misrt_q != 8'hFF) misrt_d = misrt_q + 8'd1;
    if (push && match && full && !pop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= '0;
      misrt_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      misrt_q <= misrt_d;
    end
  end

  rx_fifo_core #(
    .width (width),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (accept),
    .rd_en (pop),
    .din   (D_push),
    .dout  (D_pop),
    .count (count)
  );

  assign ovf_cnt   = ovf_q;
  assign misrt_cnt = misrt_q;

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Directed bench for bus_rx_endpoint (width=16, depth=4, my_id=3) with a
// queue scoreboard holding the packets the endpoint is expected to buffer.
module tb_bus_rx_endpoint;
  import bus_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
  localparam logic [7:0]  MY_ID = 8'h03;

  logic         clk = 1'b0;
  logic         reset;
  logic         push;
  logic [W-1:0] D_push;
  logic         pop;
  logic [W-1:0] D_pop;
  logic         pndng, full;
  logic [7:0]   ovf_cnt, misrt_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  int           m_ovf = 0;
  int           m_misrt = 0;

  always #5 clk = ~clk;

  bus_rx_endpoint #(
    .width    (W),
    .depth    (D),
    .id_w     (8),
    .my_id    (MY_ID),
    .bcast_id (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .D_push    (D_push),
    .pop       (pop),
    .D_pop     (D_pop),
    .pndng     (pndng),
    .full      (full),
    .ovf_cnt   (ovf_cnt),
    .misrt_cnt (misrt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pndng"}, 32'(pndng), 32'(exp_q.size() != 0));
    chk({tag, ".full"},  32'(full),  32'(exp_q.size() == D));
    chk({tag, ".ovf"},   32'(ovf_cnt),   32'(m_ovf));
    chk({tag, ".misrt"}, 32'(misrt_cnt), 32'(m_misrt));
    if (exp_q.size() != 0) chk({tag, ".dpop"}, 32'(D_pop), 32'(exp_q[0]));
  endtask

  // One clock of stimulus; the reference model updates the scoreboard for the same edge.
  task automatic step(input string tag, input logic p, input logic [W-1:0] d, input logic po);
    logic m, f;
    push   = p;
    D_push = d;
    pop    = po;
    m = (get_dest(64'(d), W) == MY_ID) || (get_dest(64'(d), W) == 8'hFF);
    f = (exp_q.size() == D);
    if (p && !m && m_misrt < 255) m_misrt++;
    if (p && m && f && !po && m_ovf < 255) m_ovf++;
    if (po && exp_q.size() != 0) void'(exp_q.pop_front());
    if (p && m && (!f || po)) exp_q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    chk_state(tag);
  endtask

  task automatic do_reset(input int cycles);
    reset  = 1'b1;
    push   = 1'b1;
    D_push = 16'h0301;
    pop    = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    push  = 1'b0;
    exp_q.delete();
    m_ovf   = 0;
    m_misrt = 0;
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; D_push = '0;

    do_reset(2);
    chk_state("reset");
    chk("reset.dpop", 32'(D_pop), 32'h0);

    step("single", 1'b1, 16'h03AB, 1'b0);
    chk("single.dpop", 32'(D_pop), 32'h03AB);
    step("single_pop", 1'b0, 16'h0000, 1'b1);

    step("filt_miss", 1'b1, 16'h0511, 1'b0);
    step("filt_bcast", 1'b1, 16'hFF22, 1'b0);
    chk("filt.misrt", 32'(misrt_cnt), 32'd1);
    chk("filt.dpop", 32'(D_pop), 32'hFF22);
    step("filt_pop", 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < 5; i++) step("fill", 1'b1, 16'h0300 + 16'(i), 1'b0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.ovf", 32'(ovf_cnt), 32'd1);
    for (int i = 0; i < 4; i++) step("drain1", 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < 4; i++) step("fill2", 1'b1, 16'h0310 + 16'(i), 1'b0);
    step("full_pushpop", 1'b1, 16'h0314, 1'b1);
    chk("pp.full", 32'(full), 32'd1);
    chk("pp.ovf", 32'(ovf_cnt), 32'd1);
    chk("pp.dpop", 32'(D_pop), 32'h0311);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 16'h0000, 1'b1);
    step("pop_empty", 1'b0, 16'h0000, 1'b1);
    chk("hold.dpop", 32'(D_pop), 32'h0314);

    step("empty_pushpop", 1'b1, 16'h0320, 1'b1);
    chk("epp.pndng", 32'(pndng), 32'd1);
    step("epp_pop", 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < 10; i++) step("stream", 1'b1, 16'h0340 + 16'(i), 1'b1);
    chk("stream.dpop", 32'(D_pop), 32'h0349);
    step("stream_pop", 1'b0, 16'h0000, 1'b1);

    step("mid_a", 1'b1, 16'h0350, 1'b0);
    step("mid_b", 1'b1, 16'h0351, 1'b0);
    do_reset(1);
    chk_state("mid_reset");

    for (int i = 0; i < 300; i++) step("sat", 1'b1, 16'h0500 | 16'(i[7:0]), 1'b0);
    chk("sat.misrt", 32'(misrt_cnt), 32'd255);
    chk("sat.pndng", 32'(pndng), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_rx_endpoint.md
Name: bus_rx_endpoint

Overview:
- Receive-side endpoint for one port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- Takes the bus's per-port push/D_push output and checks the destination-ID field of each packet.
- Buffers accepted packets in a FIFO and presents them to the local consumer through the same pndng/pop/D_pop handshake the bus uses on its input side.
- One instance per driver port; it is the consumer-side counterpart of the FIFOs that feed the bus.

Parameters:
- width, 16, packet size in bits (matches pckg_sz of the bus).
- depth, 8, FIFO entries; power of two, minimum 2.
- id_w, 8, destination-ID field width, located at D_push[width-1 -: id_w].
- my_id, 0, this endpoint's address.
- bcast_id, 8'hFF, broadcast address, accepted by every endpoint.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  bus strobe: D_push is valid this cycle.
- D_push  in  width  packet from the bus.
- pop  in  1  consumer removes the head entry.
- D_pop  out  width  head entry, first-word-fall-through.
- pndng  out  1  FIFO non-empty.
- full  out  1  FIFO holds depth entries.
- ovf_cnt  out  8  packets dropped because the FIFO was full; saturates at 255.
- misrt_cnt  out  8  packets dropped because of an ID mismatch; saturates at 255.

Behaviour:
- Reset (synchronous, active-high), effective at the next rising edge:
  - Pointers and occupancy go to 0.
  - pndng=0, full=0, ovf_cnt=0, misrt_cnt=0.
  - D_pop=0; storage contents are don't-care.
- Reset dominates push and pop in the same cycle. Reset in the middle of a burst discards all stored packets.
- Address match: dest = D_push[width-1 -: id_w]. A packet matches when dest==my_id or dest==bcast_id.
- Accept condition: push & match & (!full | pop). The packet is written at the tail on that edge.
- Latency: a packet accepted at edge N is visible on D_pop with pndng=1 after edge N.
- push with no match: packet is not stored; misrt_cnt increments (saturating).
- push & match & full & !pop: packet is not stored; ovf_cnt increments (saturating). The FIFO is unchanged.
- push & match & full & pop: simultaneous read and write. Occupancy stays at depth, the head advances, the new packet is stored, and ovf_cnt does not change.
- pop & pndng: the head advances on the edge.
- pop while empty: ignored; no pointer movement.
- Empty FIFO with push & match & pop in the same cycle: pop is ignored and the packet is stored (no bypass).
- D_pop while empty holds its last value; the consumer must qualify D_pop with pndng.
- Pointers are log2(depth) bits and wrap modulo depth. Occupancy is log2(depth)+1 bits.
- full = (count==depth); pndng = (count!=0). Both are registered-derived, so there is no combinational path from push/pop to either.
- Each counter increments by at most 1 per cycle and holds at 255.
- Internal states (derived from count): EMPTY -> PARTIAL on a store. PARTIAL -> FULL when count reaches depth. FULL -> PARTIAL on a pop without an accepted push. PARTIAL -> EMPTY on a pop at count 1.

Decomposition:
- Shared package bus_pkg:
  - pkt_t typedef, parameterised by width.
  - BCAST_ID_DEFAULT constant.
  - id_w constant.
  - get_dest() function, also used by the bench's checker.
- One sub-module, rx_fifo_core: storage, pointers and count, with wr_en/rd_en/dout/count.
- Address filtering and the two counters live in bus_rx_endpoint.

Test Plan (width=16, depth=4, my_id=3):
- Reset sequence:
  - Stimulus: reset=1 for 2 cycles with push=1, D_push=16'h0301.
  - Required: pndng=0, full=0, both counters 0; nothing is stored.
- Single packet:
  - Stimulus: push D_push=16'h03AB for one cycle.
  - Required: next cycle pndng=1 and D_pop=16'h03AB. Then pop=1 for one cycle gives pndng=0.
- Filtering:
  - Stimulus: push 16'h0511, then 16'hFF22.
  - Required: misrt_cnt=1; only 16'hFF22 appears on D_pop.
- Fill and overflow:
  - Stimulus: push 16'h0300..16'h0304 on consecutive cycles with pop=0.
  - Required: full=1 after the 4th packet; ovf_cnt=1. Popping out gives 0300, 0301, 0302, 0303 in order.
- Simultaneous push and pop when full:
  - Stimulus: with the FIFO full of 0310..0313, push 16'h0314 with pop=1.
  - Required: full stays 1, ovf_cnt unchanged, D_pop=0311. Draining yields 0311, 0312, 0313, 0314.
- Wrap-around and saturation:
  - Stimulus: stream 10 packets with a pop every cycle, then 300 mismatched pushes.
  - Required: data arrives in order across the pointer wrap; misrt_cnt stops at 255.
